sop_operand_loader: RTL and testbench

SOP_OPERAND_LOADER -- requirements
Module: sop_operand_loader

---
 rtl/sop_pkg.sv | 42 ++++
 rtl/sop_lat_timer.sv | 28 ++
 rtl/sop_operand_loader.sv | 156 +++++++++++++++
 tb/tb_sop_operand_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sop_pkg.sv
// Shared definitions for the sum-of-products operand loader: FSM state type,
// default parameter values and a flat reference model of d1*c1+..+d4*c4.
package sop_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } sop_state_t;

    localparam int SOP_WIDTH_DEF = 4;
    localparam int SOP_LAT_DEF   = 2;

    // Latency timer width covers the legal latency range 0..15
    localparam int SOP_LAT_W = 4;

    // Reference model works on operands up to SOP_MAX_W bits; callers zero-extend
    localparam int SOP_MAX_W = 16;
    typedef logic [2*SOP_MAX_W+1:0] sop_wide_t;

    // Four products of two SOP_MAX_W-bit values summed without any truncation
    function automatic sop_wide_t sop_ref(
        input logic [SOP_MAX_W-1:0] d1,
        input logic [SOP_MAX_W-1:0] c1,
        input logic [SOP_MAX_W-1:0] d2,
        input logic [SOP_MAX_W-1:0] c2,
        input logic [SOP_MAX_W-1:0] d3,
        input logic [SOP_MAX_W-1:0] c3,
        input logic [SOP_MAX_W-1:0] d4,
        input logic [SOP_MAX_W-1:0] c4
    );
        sop_wide_t acc;
        acc = sop_wide_t'(d1) * sop_wide_t'(c1)
            + sop_wide_t'(d2) * sop_wide_t'(c2)
            + sop_wide_t'(d3) * sop_wide_t'(c3)
            + sop_wide_t'(d4) * sop_wide_t'(c4);
        return acc;
    endfunction

endpackage

// File: rtl/sop_lat_timer.sv
// Down-counter measuring the datapath latency after a launch.
// Loaded with (latency - 1) in the launch cycle; done is high while the count is zero.
module sop_lat_timer
    import sop_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [SOP_LAT_W-1:0] load_val,
    output logic                 done
);

    logic [SOP_LAT_W-1:0] cnt_reg;

    // Load on launch, then count down and rest at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/sop_operand_loader.sv
// Serial-to-parallel operand loader for a sum-of-products datapath.
// Collects eight words (d1,c1,d2,c2,d3,c3,d4,c4), strobes launch, waits
// SOP_LAT cycles, captures the datapath result and holds it until accepted.
// Optional build macro SOP_SELFCHECK_EN adds an internal reference model and a
// registered mismatch flag compared against sop_out at capture time.
module sop_operand_loader
    import sop_pkg::*;
#(
    parameter int WIDTH   = SOP_WIDTH_DEF,
    parameter int SOP_LAT = SOP_LAT_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [WIDTH-1:0]     d1,
    output logic [WIDTH-1:0]     d2,
    output logic [WIDTH-1:0]     d3,
    output logic [WIDTH-1:0]     d4,
    output logic [WIDTH-1:0]     c1,
    output logic [WIDTH-1:0]     c2,
    output logic [WIDTH-1:0]     c3,
    output logic [WIDTH-1:0]     c4,
    output logic                 launch,
    input  logic [2*WIDTH+1:0]   sop_out,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH+1:0]   res_data,
`ifdef SOP_SELFCHECK_EN
    output logic                 mismatch,
`endif
    output logic                 busy
);

    localparam int RW = 2*WIDTH+2;
    localparam bit LAT_ZERO = (SOP_LAT == 0);
    // The launch cycle itself is the first latency cycle, so the timer starts at SOP_LAT-1
    localparam logic [SOP_LAT_W-1:0] LAT_LOAD = LAT_ZERO ? '0 : SOP_LAT_W'(SOP_LAT - 1);

    sop_state_t        state_reg, state_next;
    logic [2:0]        word_cnt_reg;
    logic [WIDTH-1:0]  ops_reg [8];
    logic [RW-1:0]     res_reg;
    logic              accept;
    logic              capture;
    logic              timer_load;
    logic              timer_done;

    assign accept     = in_valid & in_ready;
    assign timer_load = (state_reg == S_LAUNCH);
    assign capture    = ((state_reg == S_LAUNCH) && LAT_ZERO) ||
                        ((state_reg == S_WAIT) && timer_done);

    sop_lat_timer u_lat_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (LAT_LOAD),
        .done     (timer_done)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LOAD:   if (accept && (word_cnt_reg == 3'd7)) state_next = S_LAUNCH;
            S_LAUNCH: state_next = LAT_ZERO ? S_HOLD : S_WAIT;
            S_WAIT:   if (timer_done) state_next = S_HOLD;
            S_HOLD:   if (res_ready) state_next = S_LOAD;
            default:  state_next = S_LOAD;
        endcase
    end

    // Moore outputs decoded from the state and the word count
    always_comb begin
        in_ready  = (state_reg == S_LOAD);
        launch    = (state_reg == S_LAUNCH);
        res_valid = (state_reg == S_HOLD);
        busy      = !((state_reg == S_LOAD) && (word_cnt_reg == 3'd0));
    end

    // Word counter; the 3-bit wrap after word 7 restarts the next batch at d1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_reg <= 3'd0;
        end else if (accept) begin
            word_cnt_reg <= word_cnt_reg + 3'd1;
        end
    end

    // One register per operand slot, written only when its word is accepted
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ops
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ops_reg[gi] <= '0;
                end else if (accept && (word_cnt_reg == 3'(gi))) begin
                    ops_reg[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign d1 = ops_reg[0];
    assign c1 = ops_reg[1];
    assign d2 = ops_reg[2];
    assign c2 = ops_reg[3];
    assign d3 = ops_reg[4];
    assign c3 = ops_reg[5];
    assign d4 = ops_reg[6];
    assign c4 = ops_reg[7];

    // Result capture at the end of the latency window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_reg <= '0;
        end else if (capture) begin
            res_reg <= sop_out;
        end
    end

    assign res_data = res_reg;

`ifdef SOP_SELFCHECK_EN
    sop_wide_t model;
    logic      mismatch_reg;

    assign model = sop_ref(SOP_MAX_W'(ops_reg[0]), SOP_MAX_W'(ops_reg[1]),
                           SOP_MAX_W'(ops_reg[2]), SOP_MAX_W'(ops_reg[3]),
                           SOP_MAX_W'(ops_reg[4]), SOP_MAX_W'(ops_reg[5]),
                           SOP_MAX_W'(ops_reg[6]), SOP_MAX_W'(ops_reg[7]));

    // Compare the datapath result with the reference model when it is captured
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
        end else if (capture) begin
            mismatch_reg <= (sop_wide_t'(sop_out) != model);
        end
    end

    assign mismatch = mismatch_reg;
`endif

endmodule

// File: tb/tb_sop_operand_loader.sv
// Directed testbench for sop_operand_loader: a SOP_LAT=2 instance driven by a
// two-stage pipelined datapath model, and a SOP_LAT=0 instance with a
// combinational datapath. Expected results are hand-computed constants.
module tb_sop_operand_loader;

    localparam int W  = 4;
    localparam int RW = 2*W+2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // SOP_LAT=2 instance signals
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  d1, d2, d3, d4, c1, c2, c3, c4;
    logic          launch;
    logic [RW-1:0] sop_out;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [RW-1:0] res_data;
    logic          busy;
`ifdef SOP_SELFCHECK_EN
    logic          mismatch;
    logic          mismatch0;
`endif

    // SOP_LAT=0 instance signals
    logic          in_valid0 = 1'b0;
    logic          in_ready0;
    logic [W-1:0]  in_data0 = '0;
    logic [W-1:0]  e1, e2, e3, e4, f1, f2, f3, f4;
    logic          launch0;
    logic [RW-1:0] sop_out0;
    logic          res_valid0;
    logic          res_ready0 = 1'b0;
    logic [RW-1:0] res_data0;
    logic          busy0;

    sop_operand_loader #(.WIDTH(W), .SOP_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .launch(launch), .sop_out(sop_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef SOP_SELFCHECK_EN
        .mismatch(mismatch),
`endif
        .busy(busy)
    );

    sop_operand_loader #(.WIDTH(W), .SOP_LAT(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .d1(e1), .d2(e2), .d3(e3), .d4(e4), .c1(f1), .c2(f2), .c3(f3), .c4(f4),
        .launch(launch0), .sop_out(sop_out0),
        .res_valid(res_valid0), .res_ready(res_ready0), .res_data(res_data0),
`ifdef SOP_SELFCHECK_EN
        .mismatch(mismatch0),
`endif
        .busy(busy0)
    );

    // Datapath models: two pipeline stages for dut, combinational for dut0
    logic [RW-1:0] dp_comb, dp_p1 = '0, dp_p2 = '0;
    logic [RW-1:0] err_add = '0;
    assign dp_comb = RW'(d1)*RW'(c1) + RW'(d2)*RW'(c2) + RW'(d3)*RW'(c3) + RW'(d4)*RW'(c4);
    always @(posedge clk) begin
        dp_p1 <= dp_comb;
        dp_p2 <= dp_p1;
    end
    assign sop_out  = dp_p2 + err_add;
    assign sop_out0 = RW'(e1)*RW'(f1) + RW'(e2)*RW'(f2) + RW'(e3)*RW'(f3) + RW'(e4)*RW'(f4);

    // Cycle monitor for dut: launch count, launch cycle and res_valid rise cycle
    int   cyc = 0, launch_cnt = 0, launch_cyc = 0, rv_cyc = 0;
    logic rv_prev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (launch) begin
            launch_cnt <= launch_cnt + 1;
            launch_cyc <= cyc;
        end
        if (res_valid && !rv_prev) rv_cyc <= cyc;
        rv_prev <= res_valid;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Present one word to dut and hold it until accepted
    task automatic send_word(input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for dut res_valid
    task automatic wait_result();
        int n;
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("res_timeout", 0, 1);
    endtask

    // Accept the held result of dut
    task automatic release_result();
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic send_word0(input logic [W-1:0] w);
        in_valid0 = 1'b1;
        in_data0  = w;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
    endtask

    int lc0;
    logic [W-1:0] batch_a [8] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd2, 4'd1};
    logic [W-1:0] batch_r [8] = '{4'd2, 4'd3, 4'd1, 4'd4, 4'd0, 4'd5, 4'd3, 4'd3};
    logic [W-1:0] batch_z [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4};

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_launch", 32'(launch), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_d1", 32'(d1), 0);
        check("rst_res_data", 32'(res_data), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Batch 1,2,3,3,0,0,2,1 -> 13
        for (int i = 0; i < 8; i++) send_word(batch_a[i]);
        check("b1_launch", 32'(launch), 1);
        check("b1_in_ready", 32'(in_ready), 0);
        check("b1_busy", 32'(busy), 1);
        check("b1_ops", {d1, c1, d2, c2, d3, c3, d4, c4}, 32'h12330021);
        wait_result();
        check("b1_res_data", 32'(res_data), 13);

        // Stall in HOLD with a producer pushing 15s
        in_valid = 1'b1;
        in_data  = 4'd15;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_res_valid", 32'(res_valid), 1);
            check("stall_res_data", 32'(res_data), 13);
            check("stall_d1", 32'(d1), 1);
        end
        check("b1_rv_latency", 32'(rv_cyc - launch_cyc), 3);
        check("b1_launch_cnt", 32'(launch_cnt), 1);
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("rel_in_ready", 32'(in_ready), 1);
        check("rel_res_valid", 32'(res_valid), 0);
        check("rel_busy", 32'(busy), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("first_word_d1", 32'(d1), 15);
        check("first_word_busy", 32'(busy), 1);
        check("retain_c1", 32'(c1), 2);

        // Remaining all-15 words -> 900
        for (int i = 0; i < 7; i++) send_word(4'd15);
        wait_result();
        check("max_res_data", 32'(res_data), 900);
        check("max_c4", 32'(c4), 15);
        release_result();

        // Reset after 5 words discards the batch (async, checked before any edge)
        for (int i = 0; i < 5; i++) send_word(4'(i + 3));
        check("part_d3", 32'(d3), 7);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_d1", 32'(d1), 0);
        check("mid_rst_d3", 32'(d3), 0);
        check("mid_rst_res_data", 32'(res_data), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        lc0 = launch_cnt;
        for (int i = 0; i < 7; i++) send_word(batch_r[i]);
        check("r_no_launch_7", 32'(launch), 0);
        check("r_in_ready_7", 32'(in_ready), 1);
        send_word(batch_r[7]);
        check("r_launch_8", 32'(launch), 1);
        wait_result();
        check("r_res_data", 32'(res_data), 19);
        @(negedge clk); #1;
        check("r_launch_cnt", 32'(launch_cnt - lc0), 1);
        release_result();

        // Partial reload keeps the other operands
        send_word(4'd9);
        send_word(4'd9);
        check("partial_d1", 32'(d1), 9);
        check("partial_d2", 32'(d2), 1);
        for (int i = 0; i < 6; i++) send_word(4'd1);
        wait_result();
        check("p_res_data", 32'(res_data), 84);
`ifdef SOP_SELFCHECK_EN
        check("sc_good_mismatch", 32'(mismatch), 0);
`endif
        release_result();

`ifdef SOP_SELFCHECK_EN
        // Datapath returns correct+2 -> mismatch flagged
        err_add = 2;
        for (int i = 0; i < 8; i++) send_word(4'd1);
        wait_result();
        check("sc_bad_res_data", 32'(res_data), 6);
        check("sc_bad_mismatch", 32'(mismatch), 1);
        release_result();
        err_add = 0;
`endif

        // SOP_LAT=0: capture in the launch cycle, res_valid the next cycle
        check("z_in_ready", 32'(in_ready0), 1);
        for (int i = 0; i < 8; i++) send_word0(batch_z[i]);
        check("z_launch", 32'(launch0), 1);
        check("z_res_valid_l", 32'(res_valid0), 0);
        @(posedge clk); #1;
        check("z_res_valid", 32'(res_valid0), 1);
        check("z_res_data", 32'(res_data0), 30);
`ifdef SOP_SELFCHECK_EN
        check("z_mismatch", 32'(mismatch0), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
